// File: rtl/deadtime_gen_multi_pkg.sv
// Shared types and default sizing for the multi-pair dead-time generator.
package deadtime_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
    } dt_state_t;

    localparam int DEF_NUM_PAIRS   = 4;
    localparam int DEF_DT_W        = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/deadtime_gen_multi_chan.sv
// One high/low gate-drive pair: input synchronisers, command-edge detect,
// dead-band FSM with down-counter, and the registered drive/status outputs.
module deadtime_chan
    import deadtime_pkg::*;
#(
    parameter int DT_W        = DEF_DT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [DT_W-1:0] dt_cycles,
    input  logic            high_cmd,
    input  logic            low_cmd,
    output logic            high_drive,
    output logic            low_drive,
    output logic            dead_busy,
    output logic            overlap_err
);

    logic [SYNC_STAGES-1:0] high_sync;
    logic [SYNC_STAGES-1:0] low_sync;
    logic                   hs;
    logic                   ls;
    logic                   hs_p;
    logic                   ls_p;
    logic                   chg;

    dt_state_t              state;
    dt_state_t              state_next;
    logic [DT_W-1:0]        cnt;
    logic [DT_W-1:0]        cnt_next;

    assign hs  = high_sync[SYNC_STAGES-1];
    assign ls  = low_sync[SYNC_STAGES-1];
    assign chg = (hs != hs_p) | (ls != ls_p);

    // Synchronise raw commands and keep the previous synced value for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_sync <= '0;
            low_sync  <= '0;
            hs_p      <= 1'b0;
            ls_p      <= 1'b0;
        end else begin
            high_sync <= {high_sync[SYNC_STAGES-2:0], high_cmd};
            low_sync  <= {low_sync[SYNC_STAGES-2:0], low_cmd};
            hs_p      <= hs;
            ls_p      <= ls;
        end
    end

    // State and dead-band counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: disable beats a command edge, which beats band expiry.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = DEAD;
                    cnt_next   = dt_cycles;
                end
            end
            DEAD: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (chg) begin
                    cnt_next = dt_cycles;
                end else if (cnt == '0) begin
                    state_next = DRIVE;
                end else begin
                    cnt_next = cnt - DT_W'(1);
                end
            end
            DRIVE: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (chg) begin
                    state_next = DEAD;
                    cnt_next   = dt_cycles;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs derived from the state being entered; both-high never drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_drive  <= 1'b0;
            low_drive   <= 1'b0;
            dead_busy   <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            high_drive  <= (state_next == DRIVE) & hs & ~ls;
            low_drive   <= (state_next == DRIVE) & ls & ~hs;
            dead_busy   <= (state_next == DEAD);
            overlap_err <= (state == DRIVE) & hs & ls & enable;
        end
    end

endmodule

// File: rtl/deadtime_gen_multi.sv
// Multi-pair dead-time generator: NUM_PAIRS independent channels sharing
// the global enable and the dead-band programming value.
module deadtime_gen_multi
    import deadtime_pkg::*;
#(
    parameter int NUM_PAIRS   = DEF_NUM_PAIRS,
    parameter int DT_W        = DEF_DT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DT_W-1:0]      dt_cycles,
    input  logic [NUM_PAIRS-1:0] high_in,
    input  logic [NUM_PAIRS-1:0] low_in,
    output logic [NUM_PAIRS-1:0] high_out,
    output logic [NUM_PAIRS-1:0] low_out,
    output logic [NUM_PAIRS-1:0] dead_busy,
    output logic [NUM_PAIRS-1:0] overlap_err
);

    for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pair
        deadtime_chan #(
            .DT_W        (DT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (enable),
            .dt_cycles   (dt_cycles),
            .high_cmd    (high_in[g]),
            .low_cmd     (low_in[g]),
            .high_drive  (high_out[g]),
            .low_drive   (low_out[g]),
            .dead_busy   (dead_busy[g]),
            .overlap_err (overlap_err[g])
        );
    end

endmodule

// File: tb/tb_deadtime_gen_multi.sv
// Testbench for deadtime_gen_multi: directed scenarios plus randomized traffic,
// checked against a per-pair behavioural model of synchronised commands and
// elapsed dead-band time.
module tb_deadtime_gen_multi;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [DW-1:0] dt_cycles;
    logic [NP-1:0] high_in;
    logic [NP-1:0] low_in;
    logic [NP-1:0] high_out;
    logic [NP-1:0] low_out;
    logic [NP-1:0] dead_busy;
    logic [NP-1:0] overlap_err;

    int vectors     = 0;
    int miscompares = 0;

    // Model: delayed command views, previous synced value, mode 0=parked 1=band 2=driving.
    bit mh [NP][SS];
    bit ml [NP][SS];
    bit ph [NP];
    bit pl [NP];
    int mode [NP];
    int elapsed [NP];
    int band_end [NP];
    logic [NP-1:0] exp_h, exp_l, exp_busy, exp_ovl;

    deadtime_gen_multi #(
        .NUM_PAIRS   (NP),
        .DT_W        (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .dt_cycles   (dt_cycles),
        .high_in     (high_in),
        .low_in      (low_in),
        .high_out    (high_out),
        .low_out     (low_out),
        .dead_busy   (dead_busy),
        .overlap_err (overlap_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            for (int s = 0; s < SS; s++) begin
                mh[p][s] = 1'b0;
                ml[p][s] = 1'b0;
            end
            ph[p] = 1'b0;
            pl[p] = 1'b0;
            mode[p] = 0;
            elapsed[p] = 0;
            band_end[p] = 0;
        end
        exp_h = '0; exp_l = '0; exp_busy = '0; exp_ovl = '0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit hs, ls, edge_seen, was_drive;
        for (int p = 0; p < NP; p++) begin
            hs = mh[p][SS-1];
            ls = ml[p][SS-1];
            edge_seen = (hs != ph[p]) || (ls != pl[p]);
            was_drive = (mode[p] == 2);
            if (!enable) begin
                mode[p] = 0;
            end else if (mode[p] == 0 || edge_seen) begin
                mode[p] = 1;
                elapsed[p] = 0;
                band_end[p] = int'(dt_cycles);
            end else if (mode[p] == 1) begin
                if (elapsed[p] >= band_end[p]) mode[p] = 2;
                else elapsed[p] = elapsed[p] + 1;
            end
            exp_h[p]    = (mode[p] == 2) && hs && !ls;
            exp_l[p]    = (mode[p] == 2) && ls && !hs;
            exp_busy[p] = (mode[p] == 1);
            exp_ovl[p]  = was_drive && hs && ls && enable;
            ph[p] = hs;
            pl[p] = ls;
            for (int s = SS - 1; s > 0; s--) begin
                mh[p][s] = mh[p][s-1];
                ml[p][s] = ml[p][s-1];
            end
            mh[p][0] = high_in[p];
            ml[p][0] = low_in[p];
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (high_out === exp_h) else begin
            miscompares++;
            $error("FAIL %s high_out observed %b expected %b", tag, high_out, exp_h);
        end
        vectors++;
        assert (low_out === exp_l) else begin
            miscompares++;
            $error("FAIL %s low_out observed %b expected %b", tag, low_out, exp_l);
        end
        vectors++;
        assert (dead_busy === exp_busy) else begin
            miscompares++;
            $error("FAIL %s dead_busy observed %b expected %b", tag, dead_busy, exp_busy);
        end
        vectors++;
        assert (overlap_err === exp_ovl) else begin
            miscompares++;
            $error("FAIL %s overlap_err observed %b expected %b", tag, overlap_err, exp_ovl);
        end
        vectors++;
        assert ((high_out & low_out) === '0) else begin
            miscompares++;
            $error("FAIL %s both_sides observed %b expected 0", tag, high_out & low_out);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed == expected) else begin
            miscompares++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        int lat, fall_at, rise_at, busy_cnt;

        // Reset with all commands idle.
        rst_n = 1'b0; enable = 1'b0; dt_cycles = 8'd3; high_in = '0; low_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset");
        #1 rst_n = 1'b1;

        // Enable with dt=3: four-cycle band, then DRIVE with outputs low.
        enable = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step("enable_band");
            if (dead_busy[0]) busy_cnt++;
        end
        check_int("enable_band_len", busy_cnt, 4);

        // dt=5, pair0 high: rises SS+7 edges after the change.
        dt_cycles = 8'd5;
        high_in[0] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step("p0_high");
            if (high_out[0] && lat < 0) lat = i;
        end
        check_int("p0_high_latency", lat, SS + 7);

        // Swap pair0 from high to low: six-cycle gap between fall and rise.
        high_in[0] = 1'b0; low_in[0] = 1'b1;
        fall_at = -1; rise_at = -1;
        for (int i = 1; i <= 30; i++) begin
            step("p0_swap");
            if (!high_out[0] && fall_at < 0) fall_at = i;
            if (low_out[0] && rise_at < 0) rise_at = i;
        end
        check_int("p0_swap_fall", fall_at, SS + 1);
        check_int("p0_swap_gap", rise_at - fall_at, 6);

        // Glitching pair1 faster than the band keeps it dead.
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) high_in[1] = ~high_in[1];
            step("p1_glitch");
        end
        check_int("p1_glitch_busy", int'(dead_busy[1]), 1);
        check_int("p1_glitch_out", int'(high_out[1]), 0);

        // Pair2 drives high, then both commands high; then global disable.
        high_in[1] = 1'b0;
        high_in[2] = 1'b1;
        repeat (14) step("p2_high");
        low_in[2] = 1'b1;
        repeat (14) step("p2_both");
        check_int("p2_both_ovl", int'(overlap_err[2]), 1);
        enable = 1'b0;
        step("disable");
        check_int("disable_outs", int'(high_out | low_out), 0);
        high_in = '0; low_in = '0;

        // dt=10 band with dt rewritten to 2 mid-band; then async reset mid-band.
        enable = 1'b1;
        dt_cycles = 8'd10;
        repeat (20) step("settle");
        low_in[3] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 4) dt_cycles = 8'd2;
            step("p3_dtchg");
            if (low_out[3] && lat < 0) lat = i;
        end
        check_int("p3_dtchg_latency", lat, SS + 12);
        dt_cycles = 8'd10;
        low_in[3] = 1'b0;
        repeat (6) step("p3_band");
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset");
        #1 rst_n = 1'b1;

        // Maximum dt: band lasts 256 cycles.
        dt_cycles = 8'hFF;
        busy_cnt = 0;
        for (int i = 0; i < 270; i++) begin
            step("dt_max");
            if (dead_busy[0]) busy_cnt++;
        end
        check_int("dt_max_band", busy_cnt, 256);

        // Randomized commands, dead bands, enable drops and resets.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 9) == 0) high_in[p] = ~high_in[p];
                if ($urandom_range(0, 9) == 0) low_in[p] = ~low_in[p];
            end
            dt_cycles = DW'($urandom_range(0, 6));
            enable = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check("rand_reset");
                #1 rst_n = 1'b1;
            end
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
